// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, frame constants and baud timing helpers.
package uart_pkg;

    localparam int   DATA_BITS  = 8;
    localparam logic STOP_LEVEL = 1'b1;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd3,
        BREAK = 3'd4
    } rx_state_t;

    function automatic int bit_ticks(input int clock_freq, input int baud_rate);
        return clock_freq / baud_rate;
    endfunction

    function automatic int half_ticks(input int clock_freq, input int baud_rate);
        return bit_ticks(clock_freq, baud_rate) / 2;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// First-word-fall-through synchronous FIFO; head word is read straight from storage,
// status flags are registered. A push into a full FIFO succeeds only when a pop frees the slot.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           pop_data,
    output logic                       valid,
    output logic                       full,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH) + 1;

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [CW-1:0]    count_r;
    logic [CW-1:0]    count_next_s;
    logic             valid_r;
    logic             full_r;
    logic             pop_ok_s;
    logic             push_ok_s;

    // Accept/refuse decisions and next occupancy.
    always_comb begin
        pop_ok_s     = valid_r && pop;
        push_ok_s    = push && (!full_r || pop_ok_s);
        count_next_s = count_r;
        case ({push_ok_s, pop_ok_s})
            2'b10:   count_next_s = count_r + CW'(1);
            2'b01:   count_next_s = count_r - CW'(1);
            default: count_next_s = count_r;
        endcase
    end

    // Pointers, occupancy and registered status flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {CW{1'b0}};
            valid_r  <= 1'b0;
            full_r   <= 1'b0;
        end else begin
            if (push_ok_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            count_r <= count_next_s;
            valid_r <= (count_next_s != CW'(0));
            full_r  <= (count_next_s == CW'(DEPTH));
        end
    end

    // Storage; cleared on reset so the head byte reads 0 while empty after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {WIDTH{1'b0}};
            end
        end else if (push_ok_s) begin
            mem_r[wr_ptr_r] <= push_data;
        end
    end

    assign pop_data = mem_r[rd_ptr_r];
    assign valid    = valid_r;
    assign full     = full_r;
    assign count    = count_r;

endmodule

// File: rtl/uart_rx_buffered.sv
// UART 8N1 receiver: synchronizes the RX line, reassembles LSB-first bytes mid-bit
// and buffers them in a FWFT FIFO; framing and overrun events are 1-cycle pulses.
module uart_rx_buffered
    import uart_pkg::*;
#(
    parameter int CLOCK_FREQ = 50_000_000,
    parameter int BAUD_RATE  = 115_200,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          serial_in,
    output logic [7:0]                    data_out,
    output logic                          data_out_valid,
    input  logic                          data_out_ready,
    output logic                          framing_error,
    output logic                          overrun,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int BIT_TICKS = bit_ticks(CLOCK_FREQ, BAUD_RATE);
    localparam int HALF      = half_ticks(CLOCK_FREQ, BAUD_RATE);
    localparam int CNT_W     = $clog2(BIT_TICKS);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIT_TICKS - 1);
    localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'(HALF - 1);

    logic             sync1_r;
    logic             sync2_r;
    rx_state_t        state_r;
    rx_state_t        state_next_s;
    logic [CNT_W-1:0] cnt_r;
    logic [2:0]       bit_idx_r;
    logic [7:0]       shift_r;
    logic             tick_s;
    logic             shift_en_s;
    logic             push_s;
    logic             ferr_s;
    logic             full_s;
    logic             framing_error_r;
    logic             overrun_r;

    assign tick_s = (cnt_r == CNT_LAST);

    // Next-state and per-cycle event decode; the line is only ever read through sync2_r.
    always_comb begin
        state_next_s = state_r;
        shift_en_s   = 1'b0;
        push_s       = 1'b0;
        ferr_s       = 1'b0;
        case (state_r)
            IDLE: begin
                if (!sync2_r) state_next_s = START;
                else          state_next_s = IDLE;
            end
            START: begin
                if (cnt_r == CNT_MID) state_next_s = sync2_r ? IDLE : DATA;
                else                  state_next_s = START;
            end
            DATA: begin
                if (tick_s) begin
                    shift_en_s   = 1'b1;
                    state_next_s = (bit_idx_r == 3'(DATA_BITS - 1)) ? STOP : DATA;
                end else begin
                    state_next_s = DATA;
                end
            end
            STOP: begin
                if (tick_s) begin
                    if (sync2_r == STOP_LEVEL) begin
                        push_s       = 1'b1;
                        state_next_s = IDLE;
                    end else begin
                        ferr_s       = 1'b1;
                        state_next_s = BREAK;
                    end
                end else begin
                    state_next_s = STOP;
                end
            end
            BREAK: begin
                if (sync2_r) state_next_s = IDLE;
                else         state_next_s = BREAK;
            end
            default: state_next_s = IDLE;
        endcase
    end

    // Synchronizer, FSM state, bit timing and shift register; a state change restarts the timer.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_r   <= 1'b1;
            sync2_r   <= 1'b1;
            state_r   <= IDLE;
            cnt_r     <= {CNT_W{1'b0}};
            bit_idx_r <= 3'd0;
            shift_r   <= 8'hFF;
        end else begin
            sync1_r <= serial_in;
            sync2_r <= sync1_r;
            state_r <= state_next_s;
            if ((state_next_s != state_r) || tick_s) begin
                cnt_r <= {CNT_W{1'b0}};
            end else begin
                cnt_r <= cnt_r + CNT_W'(1);
            end
            if (state_next_s != state_r) begin
                bit_idx_r <= 3'd0;
            end else if (shift_en_s) begin
                bit_idx_r <= bit_idx_r + 3'd1;
            end
            if (shift_en_s) begin
                shift_r <= {sync2_r, shift_r[7:1]};
            end
        end
    end

    // Event pulses; a drop happens only when full and the head is not leaving this cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            framing_error_r <= 1'b0;
            overrun_r       <= 1'b0;
        end else begin
            framing_error_r <= ferr_s;
            overrun_r       <= push_s && full_s && !(data_out_valid && data_out_ready);
        end
    end

    sync_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst),
        .push      (push_s),
        .push_data (shift_r),
        .pop       (data_out_ready),
        .pop_data  (data_out),
        .valid     (data_out_valid),
        .full      (full_s),
        .count     (fifo_count)
    );

    assign framing_error = framing_error_r;
    assign overrun       = overrun_r;

endmodule
